// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_unit
//  Description : Iterative RV64M multiply/divide unit. It computes one bit per
//                clock and uses valid/ready handshakes on request and result.
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
    parameter int DATA_WIDTH = 64,
    parameter int WORD_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  busy
);
    localparam int c_W  = DATA_WIDTH;
    localparam int c_HW = WORD_WIDTH;
    localparam int c_CW = $clog2(DATA_WIDTH + 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CALC = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam logic [3:0] c_OP_MUL    = 4'd0;
    localparam logic [3:0] c_OP_MULH   = 4'd1;
    localparam logic [3:0] c_OP_MULHSU = 4'd2;
    localparam logic [3:0] c_OP_MULHU  = 4'd3;
    localparam logic [3:0] c_OP_DIV    = 4'd4;
    localparam logic [3:0] c_OP_REM    = 4'd6;
    localparam logic [3:0] c_OP_REMU   = 4'd7;
    localparam logic [3:0] c_OP_MULW   = 4'd8;
    localparam logic [3:0] c_OP_DIVW   = 4'd9;
    localparam logic [3:0] c_OP_REMW   = 4'd11;
    localparam logic [3:0] c_OP_REMUW  = 4'd12;

    localparam logic [c_W-1:0]  c_W_MIN  = {1'b1, {(c_W-1){1'b0}}};
    localparam logic [c_HW-1:0] c_HW_MIN = {1'b1, {(c_HW-1){1'b0}}};

    function automatic logic [c_W-1:0] sext_word(input logic [c_HW-1:0] x);
        return {{(c_W-c_HW){x[c_HW-1]}}, x};
    endfunction

    logic [1:0]       r_state;
    logic [c_CW-1:0]  r_count;
    logic [2*c_W-1:0] r_acc;   // multiply: product; divide: {remainder, dividend/quotient}
    logic [2*c_W-1:0] r_opa;   // multiply: shifting multiplicand; divide: divisor
    logic [c_W-1:0]   r_opb;   // multiply: shifting multiplier
    logic [c_W-1:0]   r_result;
    logic             r_is_mul;
    logic             r_word;
    logic             r_hi;
    logic             r_rem;
    logic             r_neg_q;
    logic             r_neg_r;

    // Request decode
    logic w_word, w_illegal, w_is_mul, w_is_div, w_is_rem, w_hi, w_a_signed, w_b_signed;
    always_comb begin
        w_word     = (op >= c_OP_MULW) && (op <= c_OP_REMUW);
        w_illegal  = op > c_OP_REMUW;
        w_is_mul   = (op <= c_OP_MULHU) || (op == c_OP_MULW);
        w_is_div   = !w_illegal && !w_is_mul;
        w_is_rem   = op inside {c_OP_REM, c_OP_REMU, c_OP_REMW, c_OP_REMUW};
        w_hi       = op inside {c_OP_MULH, c_OP_MULHSU, c_OP_MULHU};
        w_a_signed = op inside {c_OP_MUL, c_OP_MULH, c_OP_MULHSU, c_OP_DIV, c_OP_REM,
                                c_OP_MULW, c_OP_DIVW, c_OP_REMW};
        w_b_signed = op inside {c_OP_MUL, c_OP_MULH, c_OP_DIV, c_OP_REM,
                                c_OP_MULW, c_OP_DIVW, c_OP_REMW};
    end

    // Operand magnitudes at the op's width
    logic [c_HW-1:0] w_a_lo, w_b_lo, w_a_lo_mag, w_b_lo_mag;
    logic [c_W-1:0]  w_a_mag, w_b_mag, w_a_res, w_special_res;
    logic            w_a_neg, w_b_neg, w_b_zero, w_ovf, w_special;
    always_comb begin
        w_a_lo     = a[c_HW-1:0];
        w_b_lo     = b[c_HW-1:0];
        w_a_neg    = w_a_signed && (w_word ? a[c_HW-1] : a[c_W-1]);
        w_b_neg    = w_b_signed && (w_word ? b[c_HW-1] : b[c_W-1]);
        w_a_lo_mag = w_a_neg ? -w_a_lo : w_a_lo;
        w_b_lo_mag = w_b_neg ? -w_b_lo : w_b_lo;
        w_a_mag    = w_word ? {{(c_W-c_HW){1'b0}}, w_a_lo_mag} : (w_a_neg ? -a : a);
        w_b_mag    = w_word ? {{(c_W-c_HW){1'b0}}, w_b_lo_mag} : (w_b_neg ? -b : b);
        w_a_res    = w_word ? sext_word(w_a_lo) : a;
        w_b_zero   = w_word ? (w_b_lo == '0) : (b == '0);
        w_ovf      = w_is_div && w_a_signed &&
                     (w_word ? ((w_a_lo == c_HW_MIN) && (w_b_lo == '1))
                             : ((a == c_W_MIN) && (b == '1)));
        w_special  = w_illegal || (w_is_div && (w_b_zero || w_ovf));
        w_special_res = '0;
        if (w_is_div && w_b_zero) begin
            w_special_res = w_is_rem ? w_a_res : '1;
        end else if (w_ovf) begin
            w_special_res = w_is_rem ? '0 : w_a_res;
        end
    end

    // One shift-add or restoring shift-subtract step
    logic [c_W:0]     w_rem_sh;
    logic [c_W-1:0]   w_diff;
    logic             w_ge;
    logic [2*c_W-1:0] w_acc_nxt;
    always_comb begin
        w_rem_sh = {r_acc[2*c_W-1:c_W], r_acc[c_W-1]};
        w_ge     = w_rem_sh >= {1'b0, r_opa[c_W-1:0]};
        w_diff   = w_rem_sh[c_W-1:0] - r_opa[c_W-1:0];
        if (r_is_mul) begin
            w_acc_nxt = r_opb[0] ? (r_acc + r_opa) : r_acc;
        end else begin
            w_acc_nxt = {(w_ge ? w_diff : w_rem_sh[c_W-1:0]), r_acc[c_W-2:0], w_ge};
        end
    end

    // Sign fix-up and result selection, applied on the last step
    logic [2*c_W-1:0] w_prod_fix;
    logic [c_W-1:0]   w_quo_fix, w_rem_fix, w_div_sel, w_final;
    always_comb begin
        w_prod_fix = r_neg_q ? -w_acc_nxt : w_acc_nxt;
        w_quo_fix  = r_neg_q ? -w_acc_nxt[c_W-1:0] : w_acc_nxt[c_W-1:0];
        w_rem_fix  = r_neg_r ? -w_acc_nxt[2*c_W-1:c_W] : w_acc_nxt[2*c_W-1:c_W];
        w_div_sel  = r_rem ? w_rem_fix : w_quo_fix;
        if (r_is_mul) begin
            if (r_word) begin
                w_final = sext_word(w_prod_fix[c_HW-1:0]);
            end else if (r_hi) begin
                w_final = w_prod_fix[2*c_W-1:c_W];
            end else begin
                w_final = w_prod_fix[c_W-1:0];
            end
        end else begin
            w_final = r_word ? sext_word(w_div_sel[c_HW-1:0]) : w_div_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_IDLE;
            r_count  <= '0;
            r_acc    <= '0;
            r_opa    <= '0;
            r_opb    <= '0;
            r_result <= '0;
            r_is_mul <= 1'b0;
            r_word   <= 1'b0;
            r_hi     <= 1'b0;
            r_rem    <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (in_valid) begin
                        r_is_mul <= w_is_mul;
                        r_word   <= w_word;
                        r_hi     <= w_hi;
                        r_rem    <= w_is_rem;
                        r_neg_q  <= w_a_neg ^ w_b_neg;
                        r_neg_r  <= w_a_neg;
                        r_count  <= w_word ? c_CW'(c_HW - 1) : c_CW'(c_W - 1);
                        r_opb    <= w_b_mag;
                        if (w_special) begin
                            r_result <= w_special_res;
                            r_state  <= c_DONE;
                        end else begin
                            r_state <= c_CALC;
                            if (w_is_mul) begin
                                r_acc <= '0;
                                r_opa <= {{c_W{1'b0}}, w_a_mag};
                            end else begin
                                // W dividends start at the top so their MSB feeds the first step
                                r_acc <= {{c_W{1'b0}}, (w_word ? {w_a_mag[c_HW-1:0], {c_HW{1'b0}}}
                                                               : w_a_mag)};
                                r_opa <= {{c_W{1'b0}}, w_b_mag};
                            end
                        end
                    end
                end
                c_CALC: begin
                    r_acc   <= w_acc_nxt;
                    r_opb   <= r_opb >> 1;
                    r_count <= r_count - c_CW'(1);
                    if (r_is_mul) begin
                        r_opa <= r_opa << 1;
                    end
                    if (r_count == '0) begin
                        r_result <= w_final;
                        r_state  <= c_DONE;
                    end
                end
                c_DONE: begin
                    if (out_ready) begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == c_IDLE);
    assign out_valid = (r_state == c_DONE);
    assign busy      = (r_state != c_IDLE);
    assign result    = r_result;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_muldiv_unit
//  Description : Self-checking bench for muldiv_unit against an arithmetic model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;
    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] result;
    logic        busy;

    int vectors    = 0;
    int miscompares = 0;

    typedef struct {
        logic [3:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    muldiv_unit #(.DATA_WIDTH(64), .WORD_WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] sx(input logic [31:0] x);
        return {{32{x[31]}}, x};
    endfunction

    // RISC-V M-extension semantics in plain arithmetic
    function automatic logic [63:0] model(input logic [3:0] o, input logic [63:0] x, input logic [63:0] y);
        logic signed [127:0] sa, sb;
        logic [127:0]        p;
        logic signed [63:0]  s64a, s64b;
        logic signed [31:0]  s32a, s32b, t32;
        logic [31:0]         u32a, u32b, v32;
        sa = {{64{x[63]}}, x};
        sb = {{64{y[63]}}, y};
        s64a = x; s64b = y;
        s32a = x[31:0]; s32b = y[31:0];
        u32a = x[31:0]; u32b = y[31:0];
        case (o)
            4'd0: begin p = {64'd0, x} * {64'd0, y}; return p[63:0]; end
            4'd1: begin p = sa * sb; return p[127:64]; end
            4'd2: begin p = sa * $signed({64'd0, y}); return p[127:64]; end
            4'd3: begin p = {64'd0, x} * {64'd0, y}; return p[127:64]; end
            4'd4: begin
                if (y == 64'd0) return '1;
                if (x == 64'h8000_0000_0000_0000 && y == '1) return x;
                return s64a / s64b;
            end
            4'd5: return (y == 64'd0) ? '1 : x / y;
            4'd6: begin
                if (y == 64'd0) return x;
                if (x == 64'h8000_0000_0000_0000 && y == '1) return 64'd0;
                return s64a % s64b;
            end
            4'd7: return (y == 64'd0) ? x : x % y;
            4'd8: begin v32 = u32a * u32b; return sx(v32); end
            4'd9: begin
                if (u32b == 32'd0) return '1;
                if (u32a == 32'h8000_0000 && u32b == '1) return sx(u32a);
                t32 = s32a / s32b; return sx(t32);
            end
            4'd10: begin
                if (u32b == 32'd0) return '1;
                v32 = u32a / u32b; return sx(v32);
            end
            4'd11: begin
                if (u32b == 32'd0) return sx(u32a);
                if (u32a == 32'h8000_0000 && u32b == '1) return 64'd0;
                t32 = s32a % s32b; return sx(t32);
            end
            4'd12: begin
                if (u32b == 32'd0) return sx(u32a);
                v32 = u32a % u32b; return sx(v32);
            end
            default: return 64'd0;
        endcase
    endfunction

    function automatic int ref_latency(input logic [3:0] o, input logic [63:0] x, input logic [63:0] y);
        logic word;
        if (o > 4'd12) return 1;
        word = (o >= 4'd8);
        if (o <= 4'd3) return 65;
        if (o == 4'd8) return 33;
        if (word ? (y[31:0] == 32'd0) : (y == 64'd0)) return 1;
        if (o inside {4'd4, 4'd6} && x == 64'h8000_0000_0000_0000 && y == '1) return 1;
        if (o inside {4'd9, 4'd11} && x[31:0] == 32'h8000_0000 && y[31:0] == '1) return 1;
        return word ? 33 : 65;
    endfunction

    // Present one request, then count edges until out_valid (bounded)
    task automatic issue(input logic [3:0] o, input logic [63:0] x, input logic [63:0] y,
                         output logic [63:0] res, output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        op = o; a = x; b = y; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        op = 4'($urandom_range(0, 15));
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        res = result;
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = 4'd0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
        vectors++; if (result !== 64'd0) begin miscompares++; $display("FAIL reset result: got %h want 0", result); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset busy: got %b want 0", busy); end
        rst = 1'b0;
    endtask

    task automatic test_mul();
        vec_t tv[4];
        logic [63:0] r;
        int l;
        tv[0] = '{4'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65};
        tv[1] = '{4'd3, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 65};
        tv[2] = '{4'd1, '1, '1, 64'd0, 65};
        tv[3] = '{4'd2, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65};
        foreach (tv[i]) begin
            issue(tv[i].op, tv[i].a, tv[i].b, r, l);
            release_result();
            vectors++; if (r !== tv[i].exp) begin miscompares++; $display("FAIL mul[%0d] result: got %h want %h", i, r, tv[i].exp); end
            vectors++; if (l !== tv[i].lat) begin miscompares++; $display("FAIL mul[%0d] latency: got %0d want %0d", i, l, tv[i].lat); end
        end
    endtask

    task automatic test_div();
        vec_t tv[4];
        logic [63:0] r;
        int l;
        tv[0] = '{4'd4, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65};
        tv[1] = '{4'd6, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65};
        tv[2] = '{4'd5, 64'd100, 64'd7, 64'd14, 65};
        tv[3] = '{4'd7, 64'd100, 64'd7, 64'd2, 65};
        foreach (tv[i]) begin
            issue(tv[i].op, tv[i].a, tv[i].b, r, l);
            release_result();
            vectors++; if (r !== tv[i].exp) begin miscompares++; $display("FAIL div[%0d] result: got %h want %h", i, r, tv[i].exp); end
            vectors++; if (l !== tv[i].lat) begin miscompares++; $display("FAIL div[%0d] latency: got %0d want %0d", i, l, tv[i].lat); end
        end
    endtask

    task automatic test_special();
        vec_t tv[5];
        logic [63:0] r;
        int l;
        tv[0] = '{4'd4, 64'd5, 64'd0, '1, 1};
        tv[1] = '{4'd6, 64'd5, 64'd0, 64'd5, 1};
        tv[2] = '{4'd4, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1};
        tv[3] = '{4'd11, 64'h8000_0000, '1, 64'd0, 1};
        tv[4] = '{4'd14, 64'd123, 64'd45, 64'd0, 1};
        foreach (tv[i]) begin
            issue(tv[i].op, tv[i].a, tv[i].b, r, l);
            release_result();
            vectors++; if (r !== tv[i].exp) begin miscompares++; $display("FAIL special[%0d] result: got %h want %h", i, r, tv[i].exp); end
            vectors++; if (l !== tv[i].lat) begin miscompares++; $display("FAIL special[%0d] latency: got %0d want %0d", i, l, tv[i].lat); end
        end
    endtask

    task automatic test_word();
        vec_t tv[3];
        logic [63:0] r;
        int l;
        tv[0] = '{4'd10, 64'h1_8000_0000, 64'd1, 64'hFFFF_FFFF_8000_0000, 33};
        tv[1] = '{4'd8, 64'h1_0000, 64'h1_0000, 64'd0, 33};
        tv[2] = '{4'd8, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 33};
        foreach (tv[i]) begin
            issue(tv[i].op, tv[i].a, tv[i].b, r, l);
            release_result();
            vectors++; if (r !== tv[i].exp) begin miscompares++; $display("FAIL word[%0d] result: got %h want %h", i, r, tv[i].exp); end
            vectors++; if (l !== tv[i].lat) begin miscompares++; $display("FAIL word[%0d] latency: got %0d want %0d", i, l, tv[i].lat); end
        end
    endtask

    task automatic test_hold();
        logic [63:0] r;
        int l;
        issue(4'd5, 64'd100, 64'd7, r, l);
        vectors++; if (r !== 64'd14) begin miscompares++; $display("FAIL hold first result: got %h want %h", r, 64'd14); end
        // A competing request during DONE must be ignored
        op = 4'd0; a = 64'd3; b = 64'd3; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            vectors++; if (result !== 64'd14 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL hold cycle %0d: result=%h out_valid=%b in_ready=%b want 14/1/0", i, result, out_valid, in_ready);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b0;
        vectors++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL hold release: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_reset_midcalc();
        logic [63:0] r;
        int l;
        op = 4'd4; a = 64'd1000; b = 64'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL midcalc busy: got %b want 1", busy); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        vectors++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 64'd0) begin
            miscompares++;
            $display("FAIL midcalc reset: in_ready=%b out_valid=%b result=%h want 1/0/0", in_ready, out_valid, result);
        end
        issue(4'd5, 64'd9, 64'd3, r, l);
        release_result();
        vectors++; if (r !== 64'd3) begin miscompares++; $display("FAIL after reset divu: got %h want 3", r); end
        vectors++; if (l !== 65) begin miscompares++; $display("FAIL after reset latency: got %0d want 65", l); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] r;
        int l;
        issue(4'd0, 64'd3, 64'd5, r, l);
        release_result();
        vectors++; if (r !== 64'd15) begin miscompares++; $display("FAIL b2b first: got %h want %h", r, 64'd15); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b ready: got %b want 1", in_ready); end
        issue(4'd7, 64'd1000, 64'd33, r, l);
        release_result();
        vectors++; if (r !== 64'd10) begin miscompares++; $display("FAIL b2b second: got %h want %h", r, 64'd10); end
        vectors++; if (l !== 65) begin miscompares++; $display("FAIL b2b latency: got %0d want 65", l); end
    endtask

    task automatic test_random();
        logic [63:0] x, y, r, exp;
        logic [3:0]  o;
        int          l, mode, v, elat;
        for (int n = 0; n < 60; n++) begin
            o    = 4'($urandom_range(0, 15));
            mode = $urandom_range(0, 5);
            x = {$urandom, $urandom};
            y = {$urandom, $urandom};
            case (mode)
                1: begin
                    v = $urandom_range(0, 40); v -= 20; x = {{32{v[31]}}, v};
                    v = $urandom_range(0, 40); v -= 20; y = {{32{v[31]}}, v};
                end
                2: y = ($urandom_range(0, 1) == 0) ? 64'd0 : {y[63:32], 32'd0};
                3: begin
                    x = ($urandom_range(0, 1) == 0) ? 64'h8000_0000_0000_0000 : {x[63:32], 32'h8000_0000};
                    y = '1;
                end
                4: y = {32'd0, 16'd0, y[15:0]};
                default: ;
            endcase
            exp  = model(o, x, y);
            elat = ref_latency(o, x, y);
            issue(o, x, y, r, l);
            release_result();
            vectors++; if (r !== exp) begin
                miscompares++;
                $display("FAIL rand[%0d] op=%0d a=%h b=%h: got %h want %h", n, o, x, y, r, exp);
            end
            vectors++; if (l !== elat) begin
                miscompares++;
                $display("FAIL rand[%0d] latency op=%0d: got %0d want %0d", n, o, l, elat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_word();
        test_hold();
        test_reset_midcalc();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
